// File: rtl/dsub_pkg.sv
// Shared types and sizing helpers for the digit-serial PG subtractor.
package dsub_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} dsub_state_e;

   function automatic int unsigned num_digits(input int unsigned n, input int unsigned w);
      return n / w;
   endfunction

   // Digit counter width; a single-digit configuration still gets one bit.
   function automatic int unsigned cnt_width(input int unsigned k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/w_bit_pg_ripple_slice.sv
// One W-bit propagate/generate ripple digit: sum = a + nb + cin, with carry out.
module w_bit_pg_ripple_slice #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] nb,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] p;
   logic [W-1:0] g;

   assign p = a ^ nb;
   assign g = a & nb;

   always_comb begin
      logic c;
      c    = cin;
      sum  = '0;
      for (int i = 0; i < W; i++) begin
         sum[i] = p[i] ^ c;
         c      = g[i] | (p[i] & c);
      end
      cout = c;
   end

endmodule

// File: rtl/digit_serial_pg_subtractor.sv
// N-bit unsigned subtractor D = A - B - Bin computed as A + ~B + ~Bin, one W-bit digit per clock.
module digit_serial_pg_subtractor
   import dsub_pkg::*;
#(
   parameter int unsigned N = 32,
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] D,
   output logic         Bout
);

   localparam int unsigned K  = num_digits(N, W);
   localparam int unsigned CW = cnt_width(K);

   if ((W < 1) || ((N % W) != 0)) begin : g_bad_cfg
      $error("digit_serial_pg_subtractor: N must be a nonzero multiple of W");
   end

   dsub_state_e   state_q, state_d;
   logic [N-1:0]  a_q;
   logic [N-1:0]  nb_q;
   logic [N-1:0]  d_q;
   logic          bout_q;
   logic          carry_q;
   logic [CW-1:0] cnt_q;

   logic [31:0]   base;
   logic [W-1:0]  sum;
   logic          cout;
   logic          last;

   assign base = 32'(cnt_q) * W;
   assign last = (cnt_q == CW'(K - 1));

   w_bit_pg_ripple_slice #(
      .W (W)
   ) u_slice (
      .a    (a_q[base +: W]),
      .nb   (nb_q[base +: W]),
      .cin  (carry_q),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid)  state_d = StRun;
         StRun:   if (last)      state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         nb_q    <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q     <= A;
                  nb_q    <= ~B;
                  carry_q <= ~Bin;
                  cnt_q   <= '0;
               end
            end
            StRun: begin
               d_q[base +: W] <= sum;
               carry_q        <= cout;
               // Wrap to zero on the last digit so the counter never exceeds K-1.
               cnt_q          <= last ? '0 : cnt_q + 1'b1;
               if (last) begin
                  bout_q <= ~cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = rst_n && (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign D         = d_q;
   assign Bout      = bout_q;

endmodule

// File: doc/digit_serial_pg_subtractor.md
Name: digit_serial_pg_subtractor

Overview:
- Sequential N-bit unsigned subtractor: D = A - B - Bin (mod 2^N), with borrow out.
- Built as the inverse of the team's PG carry-ripple adder. Computes A + ~B + ~Bin by propagate/generate ripple, W bits per clock.
- The carry between digits is held in a register.
- Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake.
- Used wherever a narrow, area-cheap subtract or compare is needed and multi-cycle latency is acceptable.

Parameters:
- N, 32, operand/result width in bits.
- W, 8, digit width processed per clock. N must be a multiple of W and W >= 1; otherwise elaboration fails.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands A/B/Bin are valid.
- in_ready, output, 1, block can accept operands.
- A, input, N, minuend.
- B, input, N, subtrahend.
- Bin, input, 1, borrow in.
- out_valid, output, 1, D/Bout are valid.
- out_ready, input, 1, consumer accepts the result.
- D, output, N, difference.
- Bout, output, 1, borrow out. Bout = 1 iff A < B + Bin (unsigned).

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, digit counter = 0, carry register = 0.
  - D = 0, Bout = 0, out_valid = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 from the first cycle after release.
- States are IDLE, RUN and DONE. K = N/W.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On a clock edge with in_valid = 1: latch A into the operand register and ~B into the inverted-subtrahend register; carry register = ~Bin; counter = 0; go to RUN.
  - A/B/Bin are sampled only at this edge. Later changes to A/B/Bin are ignored.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge processes digit i = counter, bits [i*W +: W]:
    - bitwise P = a ^ nb, G = a & nb;
    - group PG ripple from the carry register;
    - sum digit = P ^ internal carries, written into D[i*W +: W];
    - carry register = digit carry-out;
    - counter increments.
  - D and Bout are not required to be stable during RUN; a bench checks them only when out_valid = 1.
  - On the edge that processes digit K-1:
    - Bout = ~(final carry);
    - go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - D and Bout are held stable until handshake.
  - On an edge with out_ready = 1: go to IDLE.
  - There is no accept in the same cycle as the output handshake.
- Latency:
  - Operand accept at edge E0; out_valid = 1 after edge E_K, so K cycles after accept.
  - Minimum issue interval is K+2 cycles.
- Arithmetic: all unsigned, modulo 2^N. Bin = 1 with A = B yields D = all ones, Bout = 1.
- W = N: RUN lasts exactly one cycle. W = 1: pure bit-serial, K = N cycles.
- Counter width is clog2(K), minimum 1 bit. The counter never exceeds K-1.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no out_valid pulse is produced, and the block returns to IDLE with the reset values above.
- in_valid held high while busy has no effect. out_ready while not in DONE has no effect.

Decomposition:
- Shared package dsub_pkg:
  - state enum typedef {IDLE, RUN, DONE};
  - function num_digits(N, W);
  - counter-width localparam helper.
- Sub-module w_bit_pg_ripple_slice (combinational, parameter W):
  - inputs a[W], nb[W], cin;
  - outputs sum[W], cout;
  - bitwise PG, group PG ripple, sum logic.
- Top level: FSM, operand/result registers, counter, carry register, handshakes.

Test Plan:
- N=32, W=8: A=100, B=25, Bin=0 -> D=75, Bout=0; out_valid exactly 4 cycles after accept.
- N=32, W=8: A=25, B=75, Bin=0 -> D=0xFFFFFFCE, Bout=1.
- N=32, W=8: A=0, B=0, Bin=1 -> D=0xFFFFFFFF, Bout=1. Then A=0x12345678, B=0x12345678, Bin=0 -> D=0, Bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> D/Bout unchanged, out_valid=1, in_ready=0 throughout. Pulse out_ready -> in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 after digit 1 -> out_valid, D and Bout go to 0 immediately, with no result pulse. A new operation after release (A=7, B=3) -> D=4.
- Configurations and random check:
  - W=32: latency 1 cycle.
  - W=1: latency 32 cycles.
  - 1000 random A/B/Bin with random out_ready stalls, compared against a reference model {Bout, D} = {1'b0, A} - B - Bin.
